// File: rtl/mod_sub_resolve_if.sv
// mod_sub_resolve_if
//
// Purpose:
//   Bundles the handshake and data signals of the stage-2 modular subtractor
//   resolver so that stage 1, the resolver and downstream logic share one bus.
//
// Modports:
//   master : the side that feeds stage-1 words and consumes resolved words
//            (drives in_valid/in_sign/in_result_A/in_result_B/out_ready/err_clr)
//   slave  : the resolver itself
//            (drives in_ready/out_valid/out_data/out_err/err_count)
//
// Parameters:
//   DATA_WIDTH    residue width
//   ERR_CNT_WIDTH width of the saturating fault counter

interface mod_sub_resolve_if #(
    parameter int DATA_WIDTH    = 18,
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_sign;
    logic [DATA_WIDTH-1:0]    in_result_A;
    logic [DATA_WIDTH-1:0]    in_result_B;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_err;
    logic                     err_clr;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output in_valid, in_sign, in_result_A, in_result_B, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_err, err_count
    );

    modport slave (
        input  in_valid, in_sign, in_result_A, in_result_B, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_err, err_count
    );
endinterface

// File: rtl/mod_sub_resolve.sv
// mod_sub_resolve
//
// Purpose:
//   Stage-2 resolver of the two-stage modular subtractor. Picks the canonical
//   residue from the stage-1 dual-result word, flags fault signatures, and
//   delivers {residue, fault} through a 2-entry valid/ready buffer so that
//   downstream backpressure never stalls stage 1 in the middle of a word.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   bus (slave)  in_valid/in_ready/in_sign/in_result_A/in_result_B  stage-1 side
//                out_valid/out_ready/out_data/out_err                downstream side
//                err_clr/err_count                                   fault counter
//
// Parameters:
//   DATA_WIDTH    residue width (stage-1 raw difference is DATA_WIDTH+1 bits)
//   MODULUS       channel modulus, 1 < MODULUS < 2^DATA_WIDTH
//   ERR_CNT_WIDTH width of the saturating fault counter
//
// Build option:
//   MOD_SUB_CONSIST_CHECK_EN  when defined, also flags words whose two lanes
//                             do not differ by exactly MODULUS.

module mod_sub_resolve #(
    parameter int          DATA_WIDTH    = 18,
    parameter int unsigned MODULUS       = 177147,
    parameter int          ERR_CNT_WIDTH = 16
) (
    input logic              clk,
    input logic              reset,
    mod_sub_resolve_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] MOD_W = MODULUS[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0]    w_sel;
    logic                     w_range_fault;
    logic                     w_consist_fault;
    logic                     w_err;
    logic                     w_push;
    logic                     w_pop;
    logic [1:0]               w_count_next;

    logic [DATA_WIDTH-1:0]    r_mem_data [2];
    logic [1:0]               r_mem_err;
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;
    logic                     r_in_ready;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    // A negative raw difference means the modulus-corrected lane holds the residue.
    assign w_sel         = bus.in_sign ? bus.in_result_B : bus.in_result_A;
    assign w_range_fault = (w_sel >= MOD_W);

`ifdef MOD_SUB_CONSIST_CHECK_EN
    // Both lanes come from the same A-B, so they must differ by exactly the modulus.
    logic [DATA_WIDTH-1:0] w_lane_diff;
    assign w_lane_diff     = bus.in_result_B - bus.in_result_A;
    assign w_consist_fault = (w_lane_diff != MOD_W);
`else
    assign w_consist_fault = 1'b0;
`endif

    assign w_err  = w_range_fault | w_consist_fault;
    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = (r_count != 2'd0) && bus.out_ready;

    // Next occupancy; push+pop together leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage: the write slot never equals the head slot while the buffer is
    // non-empty, so the presented head stays stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_data[0] <= '0;
            r_mem_data[1] <= '0;
            r_mem_err     <= '0;
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_sel;
            r_mem_err[r_wr_ptr]  <= w_err;
        end
    end

    // Pointers wrap naturally as 1-bit values; in_ready is registered from the
    // next occupancy so out_ready has no combinational path to in_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < 2'd2);
        end
    end

    // Saturating fault counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (bus.err_clr) begin
            r_err_count <= '0;
        end else if (w_push && w_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_mem_data[r_rd_ptr];
    assign bus.out_err   = r_mem_err[r_rd_ptr];
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_mod_sub_resolve.sv
// tb_mod_sub_resolve
//
// Purpose:
//   Self-checking bench for mod_sub_resolve. A queue-based reference model of
//   the 2-entry buffer and the fault counter is stepped every clock and
//   compared with the DUT; fixed vectors and hand-written sequences cover the
//   named scenarios. A small ERR_CNT_WIDTH keeps the saturation case short.

module tb_mod_sub_resolve;

    localparam int                DW    = 18;
    localparam int                MODV  = 177147;
    localparam int                CW    = 4;
    localparam logic [DW-1:0]     MOD_L = 18'd177147;
    localparam int                CMAX  = (1 << CW) - 1;
`ifdef MOD_SUB_CONSIST_CHECK_EN
    localparam bit CONSIST = 1'b1;
`else
    localparam bit CONSIST = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } entry_t;

    typedef struct {
        logic          sign;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
    } stage1_t;

    typedef struct {
        stage1_t       w;
        logic [DW-1:0] expData;
        logic          expErr;
        int            expCnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    entry_t modelQ[$];
    int     modelErrCnt;
    bit     modelReady;
    int     checks = 0;
    int     errors = 0;

    mod_sub_resolve_if #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) bus ();

    mod_sub_resolve #(
        .DATA_WIDTH(DW),
        .MODULUS(MODV),
        .ERR_CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch with both values.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Stage-1 dual-result word built from operands with plain integer arithmetic.
    function automatic stage1_t fromOperands(input int x, input int y);
        stage1_t w;
        int d, t;
        d = x - y;
        t = d + MODV;
        w.sign = (d < 0);
        w.ra   = d[DW-1:0];
        w.rb   = t[DW-1:0];
        return w;
    endfunction

    // Residue and fault flag of an arbitrary (possibly corrupted) raw word.
    function automatic entry_t ruleEntry(input stage1_t w);
        entry_t e;
        logic [DW-1:0] diff;
        diff   = w.rb - w.ra;
        e.data = w.sign ? w.rb : w.ra;
        e.err  = (e.data >= MOD_L) || (CONSIST && (diff != MOD_L));
        return e;
    endfunction

    // Canonical residue of a clean word, straight from (x - y) mod MODULUS.
    function automatic entry_t cleanEntry(input int x, input int y);
        entry_t e;
        int r;
        r      = ((x - y) % MODV + MODV) % MODV;
        e.data = r[DW-1:0];
        e.err  = 1'b0;
        return e;
    endfunction

    // Advances the reference model by one clock edge.
    task automatic modelStep(input bit v, input entry_t e, input bit ordy, input bit clr);
        bit push, pop;
        push = v && modelReady;
        pop  = (modelQ.size() > 0) && ordy;
        if (pop)  void'(modelQ.pop_front());
        if (push) modelQ.push_back(e);
        if (clr)
            modelErrCnt = 0;
        else if (push && e.err && modelErrCnt < CMAX)
            modelErrCnt++;
        modelReady = (modelQ.size() < 2);
    endtask

    // Compares every visible DUT output against the model.
    task automatic compareModel();
        checkOutput("out_valid", bus.out_valid, (modelQ.size() != 0));
        if (modelQ.size() != 0) begin
            checkOutput("out_data", bus.out_data, modelQ[0].data);
            checkOutput("out_err", bus.out_err, modelQ[0].err);
        end
        checkOutput("in_ready", bus.in_ready, modelReady);
        checkOutput("err_count", bus.err_count, modelErrCnt);
    endtask

    // Drives one cycle of inputs, clocks, steps the model and checks #1 later.
    task automatic applyStimulus(input bit v, input stage1_t w, input entry_t e, input bit ordy, input bit clr);
        bus.in_valid    = v;
        bus.in_sign     = w.sign;
        bus.in_result_A = w.ra;
        bus.in_result_B = w.rb;
        bus.out_ready   = ordy;
        bus.err_clr     = clr;
        @(posedge clk);
        modelStep(v, e, ordy, clr);
        #1;
        compareModel();
    endtask

    task automatic idleCycle(input bit ordy);
        stage1_t w;
        entry_t  e;
        w = '{sign: 1'b0, ra: '0, rb: '0};
        e = '{data: '0, err: 1'b0};
        applyStimulus(1'b0, w, e, ordy, 1'b0);
    endtask

    task automatic pushValue(input int val, input bit ordy);
        applyStimulus(1'b1, fromOperands(val, 0), cleanEntry(val, 0), ordy, 1'b0);
    endtask

    // Main sequence: reset, fixed vectors, backpressure, random, saturation, reset.
    initial begin
        vec_t    vecs[4];
        stage1_t w;
        stage1_t fw;
        entry_t  e;

        vecs[0] = '{w: '{sign: 1'b0, ra: 18'd2,      rb: 18'd177149}, expData: 18'd2,      expErr: 1'b0,    expCnt: 0};
        vecs[1] = '{w: '{sign: 1'b1, ra: 18'd262142, rb: 18'd177145}, expData: 18'd177145, expErr: 1'b0,    expCnt: 0};
        vecs[2] = '{w: '{sign: 1'b0, ra: 18'd177147, rb: 18'd92150},  expData: 18'd177147, expErr: 1'b1,    expCnt: 1};
        vecs[3] = '{w: '{sign: 1'b0, ra: 18'd2,      rb: 18'd177150}, expData: 18'd2,      expErr: CONSIST, expCnt: 1 + int'(CONSIST)};

        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_result_A = '0;
        bus.in_result_B = '0;
        bus.out_ready   = 1'b0;
        bus.err_clr     = 1'b0;
        modelQ.delete();
        modelErrCnt = 0;
        modelReady  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset out_data", bus.out_data, 0);
        checkOutput("reset out_err", bus.out_err, 0);
        checkOutput("reset err_count", bus.err_count, 0);
        reset = 1'b0;
        idleCycle(1'b1);
        checkOutput("post-reset in_ready", bus.in_ready, 1);

        // Fixed vectors, back to back with out_ready high.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, vecs[i].w, ruleEntry(vecs[i].w), 1'b1, 1'b0);
            checkOutput($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
            checkOutput($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].expData);
            checkOutput($sformatf("vec%0d out_err", i), bus.out_err, vecs[i].expErr);
            checkOutput($sformatf("vec%0d err_count", i), bus.err_count, vecs[i].expCnt);
        end
        idleCycle(1'b1);
        idleCycle(1'b1);

        // Backpressure: 2 and 7 fill the buffer, 9 is held off.
        pushValue(2, 1'b0);
        pushValue(7, 1'b0);
        checkOutput("full in_ready", bus.in_ready, 0);
        pushValue(9, 1'b0);
        checkOutput("held out_data", bus.out_data, 2);
        checkOutput("held in_ready", bus.in_ready, 0);
        pushValue(9, 1'b1);
        checkOutput("drain second", bus.out_data, 7);
        pushValue(9, 1'b1);
        checkOutput("drain third", bus.out_data, 9);
        for (int i = 0; i < 5; i++) begin
            pushValue(20 + i, 1'b1);
            checkOutput("steady in_ready", bus.in_ready, 1);
            checkOutput("steady out_data", bus.out_data, 20 + i);
        end
        idleCycle(1'b1);
        idleCycle(1'b1);

        // Random traffic with occasional corrupted lanes and clears.
        for (int i = 0; i < 400; i++) begin
            int x, y, b;
            x = int'($urandom_range(0, MODV - 1));
            y = int'($urandom_range(0, MODV - 1));
            w = fromOperands(x, y);
            if ($urandom_range(0, 7) == 0) begin
                b = int'($urandom_range(0, DW - 1));
                if ($urandom_range(0, 1) == 0) w.ra[b] = ~w.ra[b];
                else                           w.rb[b] = ~w.rb[b];
                e = ruleEntry(w);
            end else begin
                e = cleanEntry(x, y);
            end
            applyStimulus($urandom_range(0, 3) != 0, w, e,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end
        idleCycle(1'b1);
        idleCycle(1'b1);

        // Saturation of the fault counter, then clear against a faulty word.
        fw = '{sign: 1'b0, ra: 18'd177147, rb: 18'd92150};
        applyStimulus(1'b0, fw, ruleEntry(fw), 1'b1, 1'b1);
        for (int i = 0; i < CMAX + 2; i++)
            applyStimulus(1'b1, fw, ruleEntry(fw), 1'b1, 1'b0);
        checkOutput("saturated err_count", bus.err_count, CMAX);
        applyStimulus(1'b1, fw, ruleEntry(fw), 1'b1, 1'b1);
        checkOutput("clear priority err_count", bus.err_count, 0);
        idleCycle(1'b1);
        idleCycle(1'b1);

        // Asynchronous reset with two words buffered.
        pushValue(2, 1'b0);
        pushValue(7, 1'b0);
        checkOutput("pre-reset out_valid", bus.out_valid, 1);
        reset = 1'b1;
        modelQ.delete();
        modelErrCnt = 0;
        modelReady  = 1'b1;
        #1;
        checkOutput("async reset out_valid", bus.out_valid, 0);
        checkOutput("async reset err_count", bus.err_count, 0);
        #3;
        reset = 1'b0;
        idleCycle(1'b1);
        checkOutput("after reset in_ready", bus.in_ready, 1);
        pushValue(11, 1'b1);
        checkOutput("after reset out_data", bus.out_data, 11);
        idleCycle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
